// File: rtl/grid_pkg.sv
// Shared types and helpers for the pixel-grid overlay pipeline.
package grid_pkg;

  // Overlay modes, encoded exactly as presented on cfg_mode.
  typedef enum logic [1:0] {
    GRID_OFF  = 2'd0,
    GRID_ROW  = 2'd1,
    GRID_COL  = 2'd2,
    GRID_BOTH = 2'd3
  } grid_mode_e;

  // Widest colour channel the saturating helper can handle.
  localparam int GRID_MAX_W = 16;

  // Phase counter width for a given cell edge length; at least one bit.
  function automatic int grid_phase_w(input int scale);
    return (scale <= 2) ? 1 : $clog2(scale);
  endfunction

  // Saturating add (bright) or subtract (dark) on a 'width'-bit value.
  // Operands are zero-extended into GRID_MAX_W bits by the caller.
  function automatic logic [GRID_MAX_W-1:0] grid_sat_addsub(
    input logic [GRID_MAX_W-1:0] value,
    input logic [GRID_MAX_W-1:0] delta,
    input int unsigned           width,
    input logic                  bright
  );
    logic [GRID_MAX_W:0]   sum;
    logic [GRID_MAX_W-1:0] all_ones;
    logic [GRID_MAX_W-1:0] max_val;
    logic [GRID_MAX_W-1:0] result;
    all_ones = '1;
    max_val  = all_ones >> (GRID_MAX_W - width);
    sum      = {1'b0, value} + {1'b0, delta};
    if (bright) begin
      // A carry out of the channel width clamps to all-ones.
      result = (sum > {1'b0, max_val}) ? max_val : sum[GRID_MAX_W-1:0];
    end else begin
      // A borrow clamps to zero.
      result = (delta > value) ? '0 : (value - delta);
    end
    return result;
  endfunction

endpackage

// File: rtl/grid_sat_apply.sv
// One colour channel of the overlay: picks the delta and applies it with
// saturation. Purely combinational.
module grid_sat_apply
  import grid_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int ALPHA   = 2,
  parameter int DELTA   = 16
) (
  input  logic [PIXEL_W-1:0] value,
  input  logic               bright,
  input  logic               mult,
  output logic [PIXEL_W-1:0] result
);

  logic [PIXEL_W-1:0] delta;

  // Delta is either a fixed step or a fraction of the channel value.
  always_comb begin
    // NOTE: every signal driven in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    delta  = PIXEL_W'(DELTA);
    if (mult) delta = value >> ALPHA;
    result = PIXEL_W'(grid_sat_addsub(GRID_MAX_W'(value), GRID_MAX_W'(delta),
                                      PIXEL_W, bright));
  end

endmodule

// File: rtl/grid_overlay_pipe.sv
// Two-stage pixel-grid overlay between the scaler and the HDMI encoder.
// Tracks the position inside each SCALE x SCALE cell from line/frame start
// markers and brightens or darkens cell-edge pixels.
module grid_overlay_pipe
  import grid_pkg::*;
#(
  parameter int PIXEL_W  = 8,
  parameter int CHANNELS = 3,
  parameter int SCALE    = 4,
  parameter int ALPHA    = 2,
  parameter int DELTA    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   cfg_mode,
  input  logic                         cfg_bright,
  input  logic                         cfg_mult,
  input  logic                         pxl_in_valid,
  input  logic                         line_start,
  input  logic                         frame_start,
  input  logic [CHANNELS*PIXEL_W-1:0]  pxl_in,
  output logic                         pxl_out_valid,
  output logic [CHANNELS*PIXEL_W-1:0]  pxl_out,
  output logic                         grid_hit_out
);

  localparam int              PH_W    = grid_phase_w(SCALE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCALE - 1);
  localparam int              PX_W    = CHANNELS * PIXEL_W;

  // Phase counters and frame-shadowed configuration.
  logic [PH_W-1:0] x_phase, y_phase;
  grid_mode_e      sh_mode;
  logic            sh_bright, sh_mult;

  // Values in effect for the pixel currently at the input.
  logic [PH_W-1:0] x_cur, y_cur;
  grid_mode_e      mode_cur;
  logic            bright_cur, mult_cur;
  logic            start_frame, start_line, hit_cur;

  // Stage 1 registers.
  logic            s1_valid, s1_hit, s1_bright, s1_mult;
  logic [PX_W-1:0] s1_pxl;
  logic [PX_W-1:0] s2_applied;

  // Phase after start-marker update, config for this pixel, and hit decision.
  always_comb begin
    start_frame = pxl_in_valid & frame_start;
    start_line  = pxl_in_valid & (line_start | frame_start);
    mode_cur    = start_frame ? grid_mode_e'(cfg_mode) : sh_mode;
    bright_cur  = start_frame ? cfg_bright : sh_bright;
    mult_cur    = start_frame ? cfg_mult   : sh_mult;

    if (start_line || x_phase == PH_LAST) x_cur = '0;
    else                                  x_cur = x_phase + 1'b1;

    if (start_frame)                           y_cur = '0;
    else if (start_line && y_phase == PH_LAST) y_cur = '0;
    else if (start_line)                       y_cur = y_phase + 1'b1;
    else                                       y_cur = y_phase;

    case (mode_cur)
      GRID_ROW:  hit_cur = (y_cur == PH_LAST);
      GRID_COL:  hit_cur = (x_cur == PH_LAST);
      GRID_BOTH: hit_cur = (y_cur == PH_LAST) || (x_cur == PH_LAST);
      default:   hit_cur = 1'b0;
    endcase
  end

  // Advance phases and capture shadow config on valid pixels only.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      x_phase   <= '0;
      y_phase   <= '0;
      sh_mode   <= GRID_OFF;
      sh_bright <= 1'b0;
      sh_mult   <= 1'b0;
    end else if (pxl_in_valid) begin
      x_phase <= x_cur;
      y_phase <= y_cur;
      if (frame_start) begin
        sh_mode   <= grid_mode_e'(cfg_mode);
        sh_bright <= cfg_bright;
        sh_mult   <= cfg_mult;
      end
    end
  end

  // Stage 1 qualifier; reset drops any pixel in flight.
  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= pxl_in_valid;
  end

  // Stage 1 data, loaded with each valid pixel.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; s1_valid alone decides whether
    // they are ever consumed.
    if (pxl_in_valid) begin
      s1_pxl    <= pxl_in;
      s1_hit    <= hit_cur;
      s1_bright <= bright_cur;
      s1_mult   <= mult_cur;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    grid_sat_apply #(
      .PIXEL_W (PIXEL_W),
      .ALPHA   (ALPHA),
      .DELTA   (DELTA)
    ) u_sat (
      .value  (s1_pxl[c*PIXEL_W +: PIXEL_W]),
      .bright (s1_bright),
      .mult   (s1_mult),
      .result (s2_applied[c*PIXEL_W +: PIXEL_W])
    );
  end

  // Stage 2 outputs; hold the last pixel through valid gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      pxl_out_valid <= 1'b0;
      pxl_out       <= '0;
      grid_hit_out  <= 1'b0;
    end else begin
      pxl_out_valid <= s1_valid;
      if (s1_valid) begin
        pxl_out      <= s1_hit ? s2_applied : s1_pxl;
        grid_hit_out <= s1_hit;
      end
    end
  end

endmodule

// File: tb/tb_grid_overlay_pipe.sv
// Scoreboard bench for grid_overlay_pipe with default parameters.
module tb_grid_overlay_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic        cfg_bright, cfg_mult;
  logic        pxl_in_valid, line_start, frame_start;
  logic [23:0] pxl_in;
  logic        pxl_out_valid;
  logic [23:0] pxl_out;
  logic        grid_hit_out;

  typedef struct {
    logic [23:0] px;
    logic        hit;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  grid_overlay_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_mode      (cfg_mode),
    .cfg_bright    (cfg_bright),
    .cfg_mult      (cfg_mult),
    .pxl_in_valid  (pxl_in_valid),
    .line_start    (line_start),
    .frame_start   (frame_start),
    .pxl_in        (pxl_in),
    .pxl_out_valid (pxl_out_valid),
    .pxl_out       (pxl_out),
    .grid_hit_out  (grid_hit_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one valid pixel; optionally record what must come out 2 cycles later.
  task automatic drive(input logic [23:0] px, input logic ls, input logic fs,
                       input logic [23:0] ex, input logic eh, input logic track);
    @(posedge clk); #1;
    pxl_in_valid = 1'b1;
    line_start   = ls;
    frame_start  = fs;
    pxl_in       = px;
    if (track) sb.push_back('{px: ex, hit: eh, cyc: cyc + 2});
  endtask

  // Idle cycles with markers raised, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pxl_in_valid = 1'b0;
      line_start   = 1'b1;
      frame_start  = 1'b1;
      pxl_in       = 24'hDEADBE;
    end
  endtask

  // One 4-pixel line; only the x_phase=3 pixel may be modified.
  task automatic row4(input logic [23:0] base, input logic [23:0] px3,
                      input logic [23:0] ex3, input logic fs, input logic hit3);
    for (int p = 0; p < 4; p++)
      drive((p == 3) ? px3 : base, p == 0, fs && p == 0,
            (p == 3) ? ex3 : base, (p == 3) ? hit3 : 1'b0, 1'b1);
  endtask

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge clk) begin
    if (pxl_out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {31'd0, pxl_out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pixel", {8'd0, pxl_out}, {8'd0, e.px});
        check("hit", {31'd0, grid_hit_out}, {31'd0, e.hit});
        check("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_mode = 2'd0; cfg_bright = 1'b0; cfg_mult = 1'b0;
    pxl_in_valid = 1'b0; line_start = 1'b0; frame_start = 1'b0; pxl_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", {31'd0, pxl_out_valid}, 32'd0);
    check("reset_pxl", {8'd0, pxl_out}, 32'd0);
    check("reset_hit", {31'd0, grid_hit_out}, 32'd0);

    // 1: full grid, dark, fixed delta over 8 lines x 8 pixels.
    cfg_mode = 2'd3; cfg_bright = 1'b0; cfg_mult = 1'b0;
    for (int l = 0; l < 8; l++)
      for (int p = 0; p < 8; p++) begin
        logic h;
        h = (p % 4 == 3) || (l % 4 == 3);
        drive(24'h808080, p == 0, l == 0 && p == 0,
              h ? 24'h707070 : 24'h808080, h, 1'b1);
      end
    idle(2);

    // 2: column mode saturation, fixed delta.
    cfg_mode = 2'd2; cfg_bright = 1'b1; cfg_mult = 1'b0;
    row4(24'hF8F8F8, 24'hF0EF01, 24'hFFFF11, 1'b1, 1'b1);
    cfg_bright = 1'b0;
    row4(24'h080808, 24'h100811, 24'h000001, 1'b1, 1'b1);
    row4(24'h0F0F0F, 24'h10FF00, 24'h00EF00, 1'b0, 1'b1);
    idle(1);

    // 3: multiplicative delta.
    cfg_mult = 1'b1; cfg_bright = 1'b1;
    row4(24'h123456, 24'h40F000, 24'h50FF00, 1'b1, 1'b1);
    cfg_bright = 1'b0;
    row4(24'h654321, 24'h030480, 24'h030360, 1'b1, 1'b1);
    idle(2);

    // 4: valid gaps do not advance x_phase.
    cfg_mult = 1'b0; cfg_bright = 1'b0; cfg_mode = 2'd2;
    drive(24'h808080, 1'b1, 1'b1, 24'h808080, 1'b0, 1'b1);
    idle(3);
    drive(24'h808080, 1'b0, 1'b0, 24'h808080, 1'b0, 1'b1);
    idle(1);
    drive(24'h808080, 1'b0, 1'b0, 24'h808080, 1'b0, 1'b1);
    drive(24'h808080, 1'b0, 1'b0, 24'h707070, 1'b1, 1'b1);
    idle(2);

    // 5: mode change mid-frame waits for the next frame_start.
    cfg_mode = 2'd3;
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < 4; p++) begin
        logic h;
        if (l == 0 && p == 2) cfg_mode = 2'd0;
        h = (p == 3) || (l == 3);
        drive(24'h808080, p == 0, l == 0 && p == 0,
              h ? 24'h707070 : 24'h808080, h, 1'b1);
      end
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < 4; p++)
        drive(24'h808080, p == 0, l == 0 && p == 0, 24'h808080, 1'b0, 1'b1);
    idle(2);

    // 6: reset mid-line drops in-flight pixels and turns the overlay off.
    cfg_mode = 2'd3;
    drive(24'hF0F0F0, 1'b1, 1'b1, 24'hF0F0F0, 1'b0, 1'b1);
    drive(24'hF0F0F0, 1'b0, 1'b0, 24'hF0F0F0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; pxl_in_valid = 1'b1; line_start = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; pxl_in_valid = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, pxl_out_valid}, 32'd0);
    check("rst_pxl", {8'd0, pxl_out}, 32'd0);
    @(negedge clk);
    check("rst_drop", {31'd0, pxl_out_valid}, 32'd0);
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < 4; p++)
        drive(24'h808080, p == 0, 1'b0, 24'h808080, 1'b0, 1'b1);
    row4(24'h808080, 24'h808080, 24'h707070, 1'b1, 1'b1);
    idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
